// File: rtl/game_tick_sched.sv
// game_tick_sched: tick scheduler and game-phase controller for the Pong datapath.
//
// One shared prescaler divides clk into base_tick. Sub-counters, which advance only on
// base_tick, turn it into one-cycle clock-enable strobes for ball motion, paddle sampling
// and score blinking. A four-state phase machine gates those strobes and shortens the
// ball period on every paddle hit. No derived clocks are generated.
//
// Ports:
//   clk, rst      system clock; asynchronous active-high reset
//   start         pulse, IDLE -> SERVE
//   pause_tgl     pulse, RUN <-> PAUSE
//   hit           pulse, ball struck a paddle (speeds the ball up)
//   miss          pulse, point scored (back to SERVE)
//   game_over     pulse, any state -> IDLE
//   base_tick     registered one-cycle strobe at BASE_HZ
//   ball_tick     ball-step enable (RUN only)
//   paddle_tick   paddle-update enable (held in PAUSE)
//   blink_tick    blink enable (all states)
//   state         IDLE=0, SERVE=1, RUN=2, PAUSE=3
//   ball_div      current ball divisor in base ticks
module game_tick_sched #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BASE_HZ       = 1000,
  parameter int unsigned BALL_DIV_INIT = 20,
  parameter int unsigned BALL_DIV_MIN  = 5,
  parameter int unsigned PADDLE_DIV    = 10,
  parameter int unsigned BLINK_DIV     = 500,
  parameter int unsigned SERVE_TICKS   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause_tgl,
  input  logic       hit,
  input  logic       miss,
  input  logic       game_over,
  output logic       base_tick,
  output logic       ball_tick,
  output logic       paddle_tick,
  output logic       blink_tick,
  output logic [1:0] state,
  output logic [7:0] ball_div
);

  localparam int unsigned PrescDiv = CLK_HZ / BASE_HZ;
  localparam int unsigned PrescW   = (PrescDiv > 1) ? $clog2(PrescDiv) : 1;

  localparam logic [PrescW-1:0] PrescMax   = PrescW'(PrescDiv - 1);
  localparam logic [15:0]       PaddleLast = 16'(PADDLE_DIV - 1);
  localparam logic [15:0]       BlinkLast  = 16'(BLINK_DIV - 1);
  localparam logic [15:0]       ServeLoad  = 16'(SERVE_TICKS - 1);
  localparam logic [7:0]        BallInit   = 8'(BALL_DIV_INIT);
  localparam logic [7:0]        BallMin    = 8'(BALL_DIV_MIN);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StServe = 2'd1,
    StRun   = 2'd2,
    StPause = 2'd3
  } phase_e;

  phase_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              base_tick_q, base_tick_d;
  logic [15:0]       blink_cnt_q, blink_cnt_d;
  logic [15:0]       paddle_cnt_q, paddle_cnt_d;
  logic [15:0]       ball_cnt_q, ball_cnt_d;
  logic [15:0]       serve_cnt_q, serve_cnt_d;
  logic [7:0]        ball_div_q, ball_div_d;
  logic [15:0]       ball_last;

  // ball_div is never below 1, so this cannot wrap.
  assign ball_last = {8'd0, ball_div_q} - 16'd1;

  // Strobes come straight from registered state, so they always coincide with base_tick
  // and reflect the pre-edge phase even when an input arrives in the same cycle.
  always_comb begin
    blink_tick  = base_tick_q && (blink_cnt_q >= BlinkLast);
    paddle_tick = base_tick_q && (state_q != StPause) && (paddle_cnt_q >= PaddleLast);
    ball_tick   = base_tick_q && (state_q == StRun) && (ball_cnt_q >= ball_last);
  end

  always_comb begin
    base_tick_d = (presc_q == PrescMax);
    presc_d     = (presc_q == PrescMax) ? '0 : presc_q + PrescW'(1);

    blink_cnt_d = blink_cnt_q;
    if (base_tick_q) begin
      blink_cnt_d = blink_tick ? '0 : blink_cnt_q + 16'd1;
    end

    // Paddle and ball counters simply hold while paused, so play resumes mid-period.
    paddle_cnt_d = paddle_cnt_q;
    if (base_tick_q && (state_q != StPause)) begin
      paddle_cnt_d = paddle_tick ? '0 : paddle_cnt_q + 16'd1;
    end

    ball_cnt_d = ball_cnt_q;
    if (base_tick_q && (state_q == StRun)) begin
      ball_cnt_d = ball_tick ? '0 : ball_cnt_q + 16'd1;
    end

    serve_cnt_d = serve_cnt_q;
    if (base_tick_q && (state_q == StServe) && (serve_cnt_q != '0)) begin
      serve_cnt_d = serve_cnt_q - 16'd1;
    end

    state_d    = state_q;
    ball_div_d = ball_div_q;

    // Priority: game_over > miss > pause_tgl > hit > start.
    if (game_over) begin
      state_d    = StIdle;
      ball_div_d = BallInit;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StServe;
            serve_cnt_d = ServeLoad;
            ball_div_d  = BallInit;
          end
        end
        StServe: begin
          if (miss) begin
            serve_cnt_d = ServeLoad;
          end else if (base_tick_q && (serve_cnt_q == '0)) begin
            state_d    = StRun;
            ball_cnt_d = '0;
          end
        end
        StRun: begin
          if (miss) begin
            state_d     = StServe;
            serve_cnt_d = ServeLoad;
            ball_div_d  = BallInit;
          end else if (pause_tgl) begin
            state_d = StPause;
          end else if (hit) begin
            ball_div_d = (ball_div_q > BallMin) ? ball_div_q - 8'd1 : ball_div_q;
          end
        end
        StPause: begin
          if (pause_tgl) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      base_tick_q  <= 1'b0;
      blink_cnt_q  <= '0;
      paddle_cnt_q <= '0;
      ball_cnt_q   <= '0;
      serve_cnt_q  <= '0;
      ball_div_q   <= BallInit;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      base_tick_q  <= base_tick_d;
      blink_cnt_q  <= blink_cnt_d;
      paddle_cnt_q <= paddle_cnt_d;
      ball_cnt_q   <= ball_cnt_d;
      serve_cnt_q  <= serve_cnt_d;
      ball_div_q   <= ball_div_d;
    end
  end

  assign base_tick = base_tick_q;
  assign state     = state_q;
  assign ball_div  = ball_div_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched with a 10-cycle base period, ball divisor 4 (floor 2),
// paddle divisor 3, blink divisor 5 and a 2-tick serve. Each table row is one base-tick
// period: an optional input pulse mid-period, then the outputs in the base_tick cycle.
module tb_game_tick_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause_tgl = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       game_over = 1'b0;
  logic       base_tick, ball_tick, paddle_tick, blink_tick;
  logic [1:0] state;
  logic [7:0] ball_div;

  game_tick_sched #(
    .CLK_HZ       (100),
    .BASE_HZ      (10),
    .BALL_DIV_INIT(4),
    .BALL_DIV_MIN (2),
    .PADDLE_DIV   (3),
    .BLINK_DIV    (5),
    .SERVE_TICKS  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause_tgl  (pause_tgl),
    .hit        (hit),
    .miss       (miss),
    .game_over  (game_over),
    .base_tick  (base_tick),
    .ball_tick  (ball_tick),
    .paddle_tick(paddle_tick),
    .blink_tick (blink_tick),
    .state      (state),
    .ball_div   (ball_div)
  );

  always #5 clk = ~clk;

  // Pulse encodings: {game_over, miss, pause_tgl, hit, start}
  localparam logic [4:0] PN = 5'b00000;
  localparam logic [4:0] PS = 5'b00001;
  localparam logic [4:0] PH = 5'b00010;
  localparam logic [4:0] PP = 5'b00100;
  localparam logic [4:0] PM = 5'b01000;
  localparam logic [4:0] PG = 5'b10000;

  typedef struct {
    logic [4:0]  pulse;
    int unsigned st;
    int unsigned div;
    logic        ball;
    logic        paddle;
    logic        blink;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Outside base_tick cycles every strobe must be low.
  task automatic check_quiet();
    check("quiet", int'({base_tick, ball_tick, paddle_tick, blink_tick}), 0);
  endtask

  task automatic advance_to_base();
    for (int s = 0; s < 10; s++) begin
      step();
      if (cyc % 10 == 0) return;
      check_quiet();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL advance_to_base: got no base cycle, want one within 10 cycles");
  endtask

  task automatic add(input logic [4:0] p, input int unsigned st, input int unsigned dv,
                     input logic b, input logic pd, input logic bl);
    vec_t v;
    v.pulse  = p;
    v.st     = st;
    v.div    = dv;
    v.ball   = b;
    v.paddle = pd;
    v.blink  = bl;
    vecs.push_back(v);
  endtask

  initial begin
    // Base ticks 21..52, hand-derived.
    add(PS,      1, 4, 0, 1, 0);  // 21 start
    add(PN,      1, 4, 0, 0, 0);  // 22 serve expires -> RUN after this tick
    add(PN,      2, 4, 0, 0, 0);  // 23
    add(PN,      2, 4, 0, 1, 0);  // 24
    add(PN,      2, 4, 0, 0, 1);  // 25
    add(PN,      2, 4, 1, 0, 0);  // 26 first ball tick
    add(PN,      2, 4, 0, 1, 0);  // 27
    add(PN,      2, 4, 0, 0, 0);  // 28
    add(PN,      2, 4, 0, 0, 0);  // 29
    add(PN,      2, 4, 1, 1, 1);  // 30
    add(PH,      2, 3, 0, 0, 0);  // 31 hit -> 3
    add(PH,      2, 2, 1, 0, 0);  // 32 hit -> 2
    add(PH,      2, 2, 0, 1, 0);  // 33 hit at floor holds
    add(PN,      2, 2, 1, 0, 0);  // 34
    add(PN,      2, 2, 0, 0, 1);  // 35
    add(PN,      2, 2, 1, 1, 0);  // 36
    add(PN,      2, 2, 0, 0, 0);  // 37
    add(PP,      3, 2, 0, 0, 0);  // 38 pause
    add(PN,      3, 2, 0, 0, 0);  // 39
    add(PN,      3, 2, 0, 0, 1);  // 40 blink continues in pause
    add(PP,      2, 2, 1, 0, 0);  // 41 resume from held count
    add(PN,      2, 2, 0, 1, 0);  // 42
    add(PN,      2, 2, 1, 0, 0);  // 43
    add(PH | PM, 1, 4, 0, 0, 0);  // 44 miss beats hit
    add(PG,      0, 4, 0, 1, 1);  // 45 game_over in SERVE
    add(PH,      0, 4, 0, 0, 0);  // 46 hit ignored in IDLE
    add(PP,      0, 4, 0, 0, 0);  // 47 pause ignored in IDLE
    add(PN,      0, 4, 0, 1, 0);  // 48
    add(PS,      1, 4, 0, 0, 0);  // 49 start
    add(PN,      1, 4, 0, 0, 1);  // 50
    add(PN,      2, 4, 0, 1, 0);  // 51
    add(PH,      2, 3, 0, 0, 0);  // 52 hit -> 3

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_div", int'(ball_div), 4);
    check("rst_strobes", int'({base_tick, ball_tick, paddle_tick, blink_tick}), 0);
    rst = 1'b0;
    cyc = 0;

    // Idle: base every 10 cycles, blink every 50, paddle every 30, no ball.
    for (int i = 0; i < 200; i++) begin
      step();
      check("idle_base", int'(base_tick), int'(cyc % 10 == 0));
      check("idle_blink", int'(blink_tick), int'(cyc % 50 == 0));
      check("idle_paddle", int'(paddle_tick), int'(cyc % 30 == 0));
      check("idle_ball", int'(ball_tick), 0);
      check("idle_state", int'(state), 0);
      check("idle_div", int'(ball_div), 4);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (4) begin
        step();
        check_quiet();
      end
      {game_over, miss, pause_tgl, hit, start} = vecs[i].pulse;
      step();
      {game_over, miss, pause_tgl, hit, start} = PN;
      check_quiet();
      advance_to_base();
      check($sformatf("k%0d base", 21 + i), int'(base_tick), 1);
      check($sformatf("k%0d state", 21 + i), int'(state), int'(vecs[i].st));
      check($sformatf("k%0d div", 21 + i), int'(ball_div), int'(vecs[i].div));
      check($sformatf("k%0d ball", 21 + i), int'(ball_tick), int'(vecs[i].ball));
      check($sformatf("k%0d paddle", 21 + i), int'(paddle_tick), int'(vecs[i].paddle));
      check($sformatf("k%0d blink", 21 + i), int'(blink_tick), int'(vecs[i].blink));
    end

    // pause_tgl inside a base_tick cycle: strobes use the pre-edge RUN state.
    advance_to_base();
    check("k53 ball", int'(ball_tick), 1);
    check("k53 paddle", int'(paddle_tick), 0);
    check("k53 state", int'(state), 2);
    pause_tgl = 1'b1;
    step();
    pause_tgl = 1'b0;
    check("pause_edge state", int'(state), 3);
    check("pause_edge ball", int'(ball_tick), 0);
    advance_to_base();
    check("k54 base", int'(base_tick), 1);
    check("k54 paddle held", int'(paddle_tick), 0);
    check("k54 state", int'(state), 3);
    check("k54 div", int'(ball_div), 3);

    // Asynchronous reset inside a base_tick cycle, seen before the next edge.
    #2 rst = 1'b1;
    #1;
    check("async_state", int'(state), 0);
    check("async_div", int'(ball_div), 4);
    check("async_strobes", int'({base_tick, ball_tick, paddle_tick, blink_tick}), 0);
    #2 rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_base", int'(base_tick), int'(cyc == 10));
      check("post_rst_state", int'(state), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
